// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan channel selector.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        SCAN
    } state_t;

    // Ceiling log2 for sizing indices and counters; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value)
            result++;
        return result;
    endfunction

endpackage

// File: rtl/mux_scan_scan_counter.sv
// Dwell counter plus channel counter for scan mode. CH and WRAP present the
// position the scan takes at the coming edge, so the top can register data for it.
module scan_counter
    import mux_scan_pkg::*;
#(
    parameter int N     = 4,
    parameter int DWELL = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CLR,
    input  logic                  ADV_EN,
    output logic [clog2(N)-1:0]   CH,
    output logic                  WRAP
);

    localparam int SW = clog2(N);
    localparam int CW = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_n;
    logic [SW-1:0] ch_q;
    logic [SW-1:0] ch_n;
    logic          wrap_n;

    // Both counters wrap by comparison, so non-power-of-two N and DWELL work.
    always_comb begin
        cnt_n  = cnt_q;
        ch_n   = ch_q;
        wrap_n = 1'b0;
        if (CLR) begin
            cnt_n = '0;
            ch_n  = '0;
        end else if (ADV_EN) begin
            if (cnt_q == CW'(DWELL - 1)) begin
                cnt_n = '0;
                if (ch_q == SW'(N - 1)) begin
                    ch_n   = '0;
                    wrap_n = 1'b1;
                end else begin
                    ch_n = ch_q + 1'b1;
                end
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
            ch_q  <= '0;
        end else begin
            cnt_q <= cnt_n;
            ch_q  <= ch_n;
        end
    end

    assign CH   = ch_n;
    assign WRAP = wrap_n;

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel data selector with manual select and automatic scan.
// All outputs come straight from flops; the FSM decides what they load each edge.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int W     = 2,
    parameter int N     = 4,
    parameter int DWELL = 8,
    parameter int SW    = clog2(N)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  logic            MODE,
    input  logic [SW-1:0]   S,
    input  logic [N*W-1:0]  D,
    output logic [W-1:0]    Y,
    output logic [SW-1:0]   CH,
    output logic            VLD,
    output logic            WRAP
);

    state_t        state;
    state_t        next_state;
    logic [SW-1:0] sc_ch;
    logic          sc_wrap;
    logic          sc_clr;
    logic          man_valid;
    logic [W-1:0]  man_data;
    logic [W-1:0]  scan_data;

    always_comb begin
        if (!EN)
            next_state = IDLE;
        else if (MODE)
            next_state = SCAN;
        else
            next_state = MANUAL;
    end

    // Scan position restarts whenever scan is entered and is discarded on leaving.
    assign sc_clr = (next_state != SCAN) || (state != SCAN);

    scan_counter #(
        .N     (N),
        .DWELL (DWELL)
    ) u_scan_counter (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .CLR    (sc_clr),
        .ADV_EN (next_state == SCAN),
        .CH     (sc_ch),
        .WRAP   (sc_wrap)
    );

    // Index comparisons are done at int width so out-of-range selects read as invalid.
    always_comb begin
        man_valid = int'(S) < N;
        man_data  = '0;
        scan_data = '0;
        for (int i = 0; i < N; i++) begin
            if (i == int'(S))
                man_data = D[i*W +: W];
            if (i == int'(sc_ch))
                scan_data = D[i*W +: W];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            Y     <= '0;
            CH    <= '0;
            VLD   <= 1'b0;
            WRAP  <= 1'b0;
        end else begin
            state <= next_state;
            case (next_state)
                MANUAL: begin
                    WRAP <= 1'b0;
                    if (man_valid) begin
                        Y   <= man_data;
                        CH  <= S;
                        VLD <= 1'b1;
                    end else begin
                        Y   <= '0;
                        VLD <= 1'b0;
                    end
                end
                SCAN: begin
                    Y    <= scan_data;
                    CH   <= sc_ch;
                    VLD  <= 1'b1;
                    WRAP <= sc_wrap;
                end
                default: begin
                    Y    <= '0;
                    VLD  <= 1'b0;
                    WRAP <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel data selector with an automatic scan mode. It generalises the 2-bit enable/select multiplexer to N channels of W bits. The output is registered, and a scan sequencer steps through channels on a programmable dwell period. It sits between per-channel data sources, such as digit registers and sensor words, and a single shared consumer, such as a display driver or serial output.

## Interface
Parameters:
- W, 2: data width per channel (≥1)
- N, 4: channel count (≥2)
- DWELL, 8: clock cycles each channel is held in scan mode (≥1)
- SW, derived = clog2(N): select/channel-index width

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RST_N  in  1  reset, synchronous, active-low
- EN  in  1  block enable; 0 forces IDLE
- MODE  in  1  0 = manual select, 1 = auto scan
- S  in  SW  manual channel select
- D  in  N*W  packed channel data; channel i at D[i*W +: W]
- Y  out  W  selected channel data (registered)
- CH  out  SW  index of channel currently on Y
- VLD  out  1  Y/CH hold a valid selection
- WRAP  out  1  one-cycle pulse when scan wraps N-1 → 0

## Operation
- States: IDLE, MANUAL, SCAN. Next state is evaluated every edge: EN=0 → IDLE; EN=1 & MODE=0 → MANUAL; EN=1 & MODE=1 → SCAN.
- IDLE: Y=0, VLD=0, WRAP=0. CH holds its last value. The dwell counter clears to 0.
- MANUAL: CH←S and Y←D[S] at each edge, with VLD=1.
  - If S ≥ N (N not a power of 2): Y←0, VLD←0, CH holds.
- SCAN:
  - Dwell counter cnt runs 0..DWELL-1.
  - When cnt=DWELL-1: cnt←0 and CH←CH+1. When CH=N-1 it goes to 0 instead, and WRAP←1 for that cycle.
  - Otherwise: cnt←cnt+1 and CH holds.
  - Y←D[next CH] every edge, so Y tracks live data of the displayed channel. VLD=1.
- Entry into SCAN from IDLE or MANUAL: CH←0, cnt←0, Y←D[0], WRAP←0. The first channel is held a full DWELL cycles.
- SCAN→MANUAL: takes effect at the next edge. The scan position is discarded.
- DWELL=1: CH advances every cycle. WRAP pulses every N cycles.
- Reset (RST_N=0 at an edge, any state, including mid-scan):
  - state=IDLE, Y=0, CH=0, VLD=0, WRAP=0, cnt=0.
  - Reset has priority over EN and MODE.

## Timing
- Latency: 1 cycle from S/MODE/EN/D change to Y, CH and VLD. No combinational input-to-output path.
- Y, CH, VLD and WRAP change only on a rising CLK edge.
- WRAP is high for exactly 1 cycle, coincident with the cycle in which CH first shows 0 after N-1.
- Scan period = N*DWELL cycles per full sweep.
- Dwell counter width = clog2(DWELL), minimum 1 bit. Wrap is by compare, never by overflow.

## Structure
- Package mux_scan_pkg holds:
  - the state enum (IDLE, MANUAL, SCAN)
  - a clog2 constant function
- Sub-module scan_counter contains the dwell counter plus the channel counter with wrap.
  - Ports: CLK, RST_N, CLR, ADV_EN, CH, WRAP.
  - Parameters: N, DWELL.
- The top level contains the FSM, the output mux and the output registers.

## Test plan
Use N=4, W=2, DWELL=3, with D = {2'b11, 2'b10, 2'b01, 2'b00} (ch3..ch0).
- Reset: hold RST_N=0 for 2 cycles with EN=1 and MODE=1 → Y=0, CH=0, VLD=0, WRAP=0 throughout. Release RST_N → SCAN entered on the next edge, Y=00.
- Manual select: EN=1, MODE=0, S stepped 0,1,2,3 one per cycle → one cycle later Y=00,01,10,11, CH=S, VLD=1.
- Scan sweep: EN=1, MODE=1 for 14 cycles → CH sequence 0,0,0,1,1,1,2,2,2,3,3,3,0,0. Y matches D[CH]. WRAP=1 only in the 13th cycle.
- Mid-scan switch: change MODE 1→0 at CH=2 with S=1 → next edge CH=1, Y=01. Return MODE to 1 → CH restarts at 0 with a full 3-cycle dwell.
- Disable and live data: drop EN in SCAN → Y=0, VLD=0, CH held. Re-enable, then change D[0] to 11 during the dwell → Y=11 one cycle later.
- Reset mid-scan: assert RST_N=0 at CH=3, cnt=1 → all outputs reset next edge. After release, the sweep restarts at CH=0.
